// File: rtl/turbo_pkg.sv
// Shared turbo-chain definitions: LTE constituent-code constants and encoder FSM states.
package turbo_pkg;

  localparam int unsigned LTE_MEM = 3;
  localparam int unsigned K_MAX   = 6144;

  // Bit j is the coefficient of D^j.
  localparam logic [3:0] LTE_G0 = 4'b1101;  // feedback   1 + D^2 + D^3
  localparam logic [3:0] LTE_G1 = 4'b1011;  // parity     1 + D + D^3

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } enc_state_e;

endpackage

// File: rtl/rsc_step.sv
// One combinational RSC trellis step.
// Ports:
//   state_i      current encoder state, bit j-1 holds s[j] (bit 0 newest)
//   u_i          information bit (ignored when tail_i = 1)
//   tail_i       termination step: u is forced so the feedback bit is 0
//   sys_o        systematic / tail feedback bit
//   par_o        parity bit
//   state_nxt_o  state after the step
module rsc_step #(
  parameter int unsigned      MEM     = 3,
  parameter logic [MEM:0]     FB_POLY = 4'b1101,
  parameter logic [MEM:0]     FF_POLY = 4'b1011
) (
  input  logic [MEM-1:0] state_i,
  input  logic           u_i,
  input  logic           tail_i,
  output logic           sys_o,
  output logic           par_o,
  output logic [MEM-1:0] state_nxt_o
);

  logic fb_c;
  logic u_c;
  logic a_c;

  // Feedback taps over s[1..MEM]; FB_POLY[0] is the implicit input tap.
  assign fb_c = ^(FB_POLY[MEM:1] & state_i);
  // In tail steps u equals the feedback sum, so the shifted-in bit is 0.
  assign u_c  = tail_i ? fb_c : u_i;
  assign a_c  = u_c ^ fb_c;

  assign sys_o       = u_c;
  assign par_o       = (FF_POLY[0] & a_c) ^ (^(FF_POLY[MEM:1] & state_i));
  assign state_nxt_o = (state_i << 1) | MEM'(a_c);

endmodule

// File: rtl/rsc_term_encoder.sv
// Streaming RSC constituent encoder with run-time block length and built-in
// trellis termination (MEM tail beats per block).
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start, blk_len       block request and length, sampled in IDLE only
//   in_valid/in_ready    information-bit handshake, in_bit payload
//   out_valid/out_ready  output-beat handshake
//   sys_out, par_out     systematic (or tail feedback) bit and parity bit
//   tail_flag, out_last  beat is a tail beat / final tail beat
//   busy, done, err      not idle / block-finished pulse / illegal-length pulse
module rsc_term_encoder #(
  parameter int unsigned  MEM     = turbo_pkg::LTE_MEM,
  parameter logic [MEM:0] FB_POLY = turbo_pkg::LTE_G0,
  parameter logic [MEM:0] FF_POLY = turbo_pkg::LTE_G1,
  parameter int unsigned  K_MAX   = turbo_pkg::K_MAX,
  parameter int unsigned  K_W     = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K_W-1:0] blk_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_bit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sys_out,
  output logic           par_out,
  output logic           tail_flag,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic           err
);
  import turbo_pkg::*;

  enc_state_e     state_q, state_d;
  logic [MEM-1:0] enc_q, enc_d;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic           ov_q, ov_d;
  logic           sys_q, sys_d;
  logic           par_q, par_d;
  logic           tail_q, tail_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           slot_free_c;
  logic           len_ok_c;
  logic           step_sys_c;
  logic           step_par_c;
  logic [MEM-1:0] step_nxt_c;

  rsc_step #(
    .MEM     (MEM),
    .FB_POLY (FB_POLY),
    .FF_POLY (FF_POLY)
  ) u_step (
    .state_i     (enc_q),
    .u_i         (in_bit),
    .tail_i      (state_q == TAIL),
    .sys_o       (step_sys_c),
    .par_o       (step_par_c),
    .state_nxt_o (step_nxt_c)
  );

  // Output register is free when empty or being drained this cycle.
  assign slot_free_c = !ov_q || out_ready;
  assign len_ok_c    = (blk_len != '0) && (32'(blk_len) <= K_MAX);
  assign in_ready    = (state_q == DATA) && slot_free_c;

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    sys_d   = sys_q;
    par_d   = par_q;
    tail_d  = tail_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Beat drained with nothing new behind it: empty the slot.
    if (ov_q && out_ready) begin
      ov_d   = 1'b0;
      sys_d  = 1'b0;
      par_d  = 1'b0;
      tail_d = 1'b0;
      last_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            enc_d   = '0;
            cnt_d   = blk_len;
            state_d = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (in_valid && in_ready) begin
          enc_d  = step_nxt_c;
          ov_d   = 1'b1;
          sys_d  = step_sys_c;
          par_d  = step_par_c;
          tail_d = 1'b0;
          last_d = 1'b0;
          cnt_d  = cnt_q - K_W'(1);
          if (cnt_q == K_W'(1)) begin
            cnt_d   = K_W'(MEM);
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (slot_free_c) begin
          enc_d  = step_nxt_c;
          ov_d   = 1'b1;
          sys_d  = step_sys_c;
          par_d  = step_par_c;
          tail_d = 1'b1;
          last_d = (cnt_q == K_W'(1));
          cnt_d  = cnt_q - K_W'(1);
          if (cnt_q == K_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Last beat is accepted now (or already gone).
        if (slot_free_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      enc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      sys_q   <= 1'b0;
      par_q   <= 1'b0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = ov_q;
  assign sys_out   = sys_q;
  assign par_out   = par_q;
  assign tail_flag = tail_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // Termination must leave the trellis in the zero state.
  ap_term_zero: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DONE) |-> (enc_q == '0));

endmodule

// File: tb/tb_rsc_term_encoder.sv
// Scoreboard bench for rsc_term_encoder (default LTE parameters).
module tb_rsc_term_encoder;

  localparam int unsigned MEM = 3;
  localparam logic [3:0]  FB  = 4'b1101;
  localparam logic [3:0]  FF  = 4'b1011;

  typedef struct packed {
    logic sys;
    logic par;
    logic tail;
    logic last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] blk_len;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic        out_valid;
  logic        out_ready;
  logic        sys_out;
  logic        par_out;
  logic        tail_flag;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int    n_cmp;
  int    n_mis;
  beat_t exp_q[$];
  bit    blk_bits[$];
  bit    m_s[1:3];

  rsc_term_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .blk_len   (blk_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sys_out   (sys_out),
    .par_out   (par_out),
    .tail_flag (tail_flag),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference trellis step: pushes the expected beat onto the scoreboard.
  task automatic model_step(input bit u_in, input bit is_tail, input bit is_last);
    bit fb, u, a, z;
    fb = 1'b0;
    for (int j = 1; j <= 3; j++) fb = fb ^ (FB[j] & m_s[j]);
    u = is_tail ? fb : u_in;
    a = u ^ fb;
    z = FF[0] & a;
    for (int j = 1; j <= 3; j++) z = z ^ (FF[j] & m_s[j]);
    for (int j = 3; j >= 2; j--) m_s[j] = m_s[j-1];
    m_s[1] = a;
    exp_q.push_back('{sys: u, par: z, tail: is_tail, last: is_last});
  endtask

  // Runs one block from blk_bits. Caller must be at a negedge with DUT idle.
  // rdy_mode 0: out_ready/in_valid held high; 1: both pseudo-random.
  task automatic run_block(input string name, input int k, input int rdy_mode,
                           input bit use_model, input bit mid_start);
    int    idx, beats, cyc;
    bit    exp_done, stalled;
    beat_t held, got, want;
    idx = 0; beats = 0; cyc = 0; exp_done = 0; stalled = 0; held = '0;
    if (use_model) begin
      for (int j = 1; j <= 3; j++) m_s[j] = 1'b0;
      exp_q.delete();
    end
    start = 1'b1; blk_len = 13'(k);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    forever begin
      if (cyc > 3000) begin
        n_cmp++; n_mis++;
        $display("FAIL %s timeout: got no done after %0d cycles expected done", name, cyc);
        break;
      end
      n_cmp++;
      if (done !== exp_done) begin
        n_mis++; $display("FAIL %s done_pulse: got %b expected %b (cycle %0d)", name, done, exp_done, cyc);
      end
      n_cmp++;
      if (err !== 1'b0) begin
        n_mis++; $display("FAIL %s no_err: got %b expected 0", name, err);
      end
      if (done) break;
      exp_done = 1'b0;
      if (stalled) begin
        got = {sys_out, par_out, tail_flag, out_last};
        n_cmp++;
        if (out_valid !== 1'b1 || got !== held) begin
          n_mis++;
          $display("FAIL %s stall_stable: got v=%b %b expected v=1 %b", name, out_valid, got, held);
        end
      end
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid  = (idx < k) && ((rdy_mode == 0) || ($urandom_range(0, 3) != 0));
      in_bit    = (idx < k) ? blk_bits[idx] : 1'b0;
      start     = mid_start && (cyc == 5);
      if (mid_start && cyc == 5) blk_len = 13'd2;
      #1;
      if (in_valid && in_ready) begin
        if (use_model) model_step(in_bit, 1'b0, 1'b0);
        idx++;
        if (use_model && idx == k)
          for (int t = 0; t < int'(MEM); t++) model_step(1'b0, 1'b1, t == int'(MEM) - 1);
      end
      if (out_valid && out_ready) begin
        got = {sys_out, par_out, tail_flag, out_last};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++; $display("FAIL %s extra_beat: got %b expected none", name, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_mis++; $display("FAIL %s beat%0d sys/par/tail/last: got %b expected %b", name, beats, got, want);
          end
        end
        beats++;
        if (out_last) exp_done = 1'b1;
      end
      stalled = out_valid && !out_ready;
      held    = {sys_out, par_out, tail_flag, out_last};
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (beats != k + int'(MEM) || exp_q.size() != 0) begin
      n_mis++; $display("FAIL %s beat_count: got %0d (left %0d) expected %0d", name, beats, exp_q.size(), k + int'(MEM));
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++; $display("FAIL %s busy_after_done: got %b expected 0", name, busy);
    end
  endtask

  task automatic load_basic();
    blk_bits = '{1'b1, 1'b0, 1'b0};
    exp_q.delete();
    exp_q.push_back(4'b1100); exp_q.push_back(4'b0100); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1010); exp_q.push_back(4'b1010); exp_q.push_back(4'b1111);
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    rst = 1'b0; start = 1'b0; blk_len = '0; in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
    #13;
    outs = {in_ready, out_valid, sys_out, par_out, tail_flag, out_last, busy, done, err};
    n_cmp++;
    if (outs !== 9'b0) begin
      n_mis++; $display("FAIL reset_outputs: got %b expected 000000000", outs);
    end
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic();
    run_block("basic_k3", 3, 0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random_stall();
    blk_bits.delete();
    for (int i = 0; i < 40; i++) blk_bits.push_back(1'($urandom_range(0, 1)));
    run_block("rand_k40", 40, 1, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_illegal_len();
    logic [12:0] lens[2];
    lens[0] = 13'd0; lens[1] = 13'd6145;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; blk_len = lens[i]; in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({err, busy, in_ready} !== 3'b100) begin
        n_mis++; $display("FAIL illegal_len_%0d err/busy/in_ready: got %b expected 100", lens[i], {err, busy, in_ready});
      end
      @(negedge clk);
      n_cmp++;
      if ({err, busy} !== 2'b00) begin
        n_mis++; $display("FAIL illegal_len_%0d err_one_cycle: got %b expected 00", lens[i], {err, busy});
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_mid_start();
    blk_bits.delete();
    for (int i = 0; i < 20; i++) blk_bits.push_back(1'($urandom_range(0, 1)));
    run_block("mid_start_k20", 20, 0, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int    tcnt, cyc;
    beat_t got;
    logic [8:0] outs;
    tcnt = 0; cyc = 0;
    start = 1'b1; blk_len = 13'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = (i == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    while (cyc < 20) begin
      if (out_valid && tail_flag) tcnt++;
      if (tcnt == 2) break;
      @(negedge clk);
      cyc++;
    end
    got = {sys_out, par_out, tail_flag, out_last};
    n_cmp++;
    if (tcnt != 2 || got !== 4'b1010) begin
      n_mis++; $display("FAIL rst_mid tail2_beat: got %b (tail beats %0d) expected 1010", got, tcnt);
    end
    #2 rst = 1'b0;
    #1;
    outs = {in_ready, out_valid, sys_out, par_out, tail_flag, out_last, busy, done, err};
    n_cmp++;
    if (outs !== 9'b0) begin
      n_mis++; $display("FAIL rst_mid outputs: got %b expected 000000000", outs);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, busy, out_valid} !== 3'b000) begin
        n_mis++; $display("FAIL rst_mid no_done: got %b expected 000", {done, busy, out_valid});
      end
    end
    load_basic();
    run_block("after_rst_k3", 3, 0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    blk_bits.delete();
    for (int i = 0; i < 12; i++) blk_bits.push_back(1'($urandom_range(0, 1)));
    run_block("b2b_first", 12, 0, 1'b1, 1'b0);
    // start in the same slot where done is seen: sampled in IDLE right away
    blk_bits.delete();
    for (int i = 0; i < 9; i++) blk_bits.push_back(1'(i % 2 == 0));
    run_block("b2b_second", 9, 1, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    test_reset();
    test_basic();
    test_random_stall();
    test_illegal_len();
    test_mid_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
